// File: rtl/ps2_pkg.sv
// Purpose : shared scan-code constants, pop FSM encoding and held-key record
//           for the PS/2 scan-code-set-2 decoder.
// Contents: SC_* scan-code localparams, pop_state_e, held_key_t, is_status_byte().
package ps2_pkg;

   localparam int unsigned BYTE_W = 8;

   localparam logic [BYTE_W-1:0] SC_E0     = 8'hE0;
   localparam logic [BYTE_W-1:0] SC_E1     = 8'hE1;
   localparam logic [BYTE_W-1:0] SC_F0     = 8'hF0;
   localparam logic [BYTE_W-1:0] SC_LSHIFT = 8'h12;
   localparam logic [BYTE_W-1:0] SC_RSHIFT = 8'h59;
   localparam logic [BYTE_W-1:0] SC_CAPS   = 8'h58;
   localparam logic [BYTE_W-1:0] SC_BAT    = 8'hAA;
   localparam logic [BYTE_W-1:0] SC_ACK    = 8'hFA;
   localparam logic [BYTE_W-1:0] SC_RESEND = 8'hFE;
   localparam logic [BYTE_W-1:0] SC_ECHO   = 8'hEE;
   localparam logic [BYTE_W-1:0] SC_ERR0   = 8'h00;
   localparam logic [BYTE_W-1:0] SC_ERR1   = 8'hFF;
   localparam logic [BYTE_W-1:0] SC_SPACE  = 8'h29;
   localparam logic [BYTE_W-1:0] SC_ENTER  = 8'h5A;
   localparam logic [BYTE_W-1:0] SC_BKSP   = 8'h66;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_POP  = 1'b1
   } pop_state_e;

   typedef struct packed {
      logic              valid;
      logic              ext;
      logic [BYTE_W-1:0] code;
   } held_key_t;

   // Keyboard status/handshake bytes that never form a key event.
   function automatic logic is_status_byte(input logic [BYTE_W-1:0] b);
      return (b == SC_BAT) || (b == SC_ACK) || (b == SC_RESEND) ||
             (b == SC_ECHO) || (b == SC_ERR0) || (b == SC_ERR1);
   endfunction

endpackage

// File: rtl/ps2_ascii_rom.sv
// Purpose : combinational scan-code-set-2 to ASCII lookup.
// Ports   : i_code   - base scan code (prefixes already stripped)
//           i_shift  - shift held, selects shifted digit/punctuation glyphs
//           i_upper  - letters in upper case (shift xor caps)
//           o_ascii_c- ASCII result, 00h for unmapped codes
module ps2_ascii_rom
   import ps2_pkg::*;
(
   input  logic [BYTE_W-1:0] i_code,
   input  logic              i_shift,
   input  logic              i_upper,
   output logic [BYTE_W-1:0] o_ascii_c
);

   logic [BYTE_W-1:0] w_letter;
   logic [BYTE_W-1:0] w_base;
   logic [BYTE_W-1:0] w_shifted;

   // Letters carry only a lower-case glyph; everything else a base/shifted pair.
   always_comb begin
      w_letter  = '0;
      w_base    = '0;
      w_shifted = '0;
      case (i_code)
         8'h1C: w_letter = "a";
         8'h32: w_letter = "b";
         8'h21: w_letter = "c";
         8'h23: w_letter = "d";
         8'h24: w_letter = "e";
         8'h2B: w_letter = "f";
         8'h34: w_letter = "g";
         8'h33: w_letter = "h";
         8'h43: w_letter = "i";
         8'h3B: w_letter = "j";
         8'h42: w_letter = "k";
         8'h4B: w_letter = "l";
         8'h3A: w_letter = "m";
         8'h31: w_letter = "n";
         8'h44: w_letter = "o";
         8'h4D: w_letter = "p";
         8'h15: w_letter = "q";
         8'h2D: w_letter = "r";
         8'h1B: w_letter = "s";
         8'h2C: w_letter = "t";
         8'h3C: w_letter = "u";
         8'h2A: w_letter = "v";
         8'h1D: w_letter = "w";
         8'h22: w_letter = "x";
         8'h35: w_letter = "y";
         8'h1A: w_letter = "z";
         8'h45: begin w_base = "0";  w_shifted = ")";  end
         8'h16: begin w_base = "1";  w_shifted = "!";  end
         8'h1E: begin w_base = "2";  w_shifted = "@";  end
         8'h26: begin w_base = "3";  w_shifted = "#";  end
         8'h25: begin w_base = "4";  w_shifted = "$";  end
         8'h2E: begin w_base = "5";  w_shifted = "%";  end
         8'h36: begin w_base = "6";  w_shifted = "^";  end
         8'h3D: begin w_base = "7";  w_shifted = "&";  end
         8'h3E: begin w_base = "8";  w_shifted = "*";  end
         8'h46: begin w_base = "9";  w_shifted = "(";  end
         8'h0E: begin w_base = 8'h60; w_shifted = "~";  end
         8'h4E: begin w_base = "-";  w_shifted = "_";  end
         8'h55: begin w_base = "=";  w_shifted = "+";  end
         8'h54: begin w_base = "[";  w_shifted = "{";  end
         8'h5B: begin w_base = "]";  w_shifted = "}";  end
         8'h5D: begin w_base = "\\"; w_shifted = "|";  end
         8'h4C: begin w_base = ";";  w_shifted = ":";  end
         8'h52: begin w_base = "'";  w_shifted = "\""; end
         8'h41: begin w_base = ",";  w_shifted = "<";  end
         8'h49: begin w_base = ".";  w_shifted = ">";  end
         8'h4A: begin w_base = "/";  w_shifted = "?";  end
         SC_SPACE: begin w_base = 8'h20; w_shifted = 8'h20; end
         SC_ENTER: begin w_base = 8'h0D; w_shifted = 8'h0D; end
         SC_BKSP:  begin w_base = 8'h08; w_shifted = 8'h08; end
         default: ;
      endcase

      if (w_letter != '0) begin
         o_ascii_c = i_upper ? (w_letter - 8'h20) : w_letter;
      end else begin
         o_ascii_c = i_shift ? w_shifted : w_base;
      end
   end

endmodule

// File: rtl/ps2_scancode_decoder.sv
// Purpose : pops scan-code-set-2 bytes from the PS/2 receiver FIFO, folds
//           E0/F0/E1 prefixes into single key events and tracks modifiers.
// Ports   : clk, clrn (sync, active-high reset)
//           ps2_data/ps2_ready - FIFO head byte and non-empty flag
//           nextdata_n         - active-low one-cycle pop request
//           key_valid + key_code/key_ext/key_break/key_repeat/key_ascii - event
//           shift, caps        - modifier state
//           press_count        - count of non-repeat presses (wraps)
module ps2_scancode_decoder
   import ps2_pkg::*;
#(
   parameter int unsigned CNT_W   = 8,
   parameter int unsigned E1_SKIP = 7
) (
   input  logic              clk,
   input  logic              clrn,
   input  logic [BYTE_W-1:0] ps2_data,
   input  logic              ps2_ready,
   output logic              nextdata_n,
   output logic              key_valid,
   output logic [BYTE_W-1:0] key_code,
   output logic              key_ext,
   output logic              key_break,
   output logic              key_repeat,
   output logic [BYTE_W-1:0] key_ascii,
   output logic              shift,
   output logic              caps,
   output logic [CNT_W-1:0]  press_count
);

   localparam int unsigned SKIP_W = (E1_SKIP < 1) ? 1 : $clog2(E1_SKIP + 1);

   pop_state_e        r_state;
   pop_state_e        w_state_nxt;
   logic              w_capture;

   logic [SKIP_W-1:0] r_skip_cnt;
   logic              r_ext_pend;
   logic              r_brk_pend;
   held_key_t         r_held;
   logic              r_lshift;
   logic              r_rshift;

   logic              w_in_skip;
   logic              w_event;
   logic              w_is_make;
   logic              w_plain;
   logic              w_held_match;
   logic              w_repeat;
   logic              w_lshift_nxt;
   logic              w_rshift_nxt;
   logic              w_caps_nxt;
   logic [BYTE_W-1:0] w_rom_ascii;
   logic [BYTE_W-1:0] w_ascii;

   // Pop FSM state register.
   always_ff @(posedge clk) begin
      if (clrn) r_state <= S_IDLE;
      else      r_state <= w_state_nxt;
   end

   // Pop FSM: capture only in S_IDLE so the FIFO has a cycle to advance.
   always_comb begin
      w_state_nxt = r_state;
      w_capture   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (ps2_ready) begin
               w_capture   = 1'b1;
               w_state_nxt = S_POP;
            end
         end
         S_POP:   w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Byte classification and modifier next-state for the captured byte.
   always_comb begin
      w_in_skip    = (r_skip_cnt != '0);
      w_event      = w_capture && !w_in_skip && (ps2_data != SC_E1) &&
                     (ps2_data != SC_E0) && (ps2_data != SC_F0) &&
                     !is_status_byte(ps2_data);
      w_is_make    = !r_brk_pend;
      w_plain      = !r_ext_pend;
      w_held_match = r_held.valid && (r_held.ext == r_ext_pend) &&
                     (r_held.code == ps2_data);
      w_repeat     = w_is_make && w_held_match;

      w_lshift_nxt = r_lshift;
      w_rshift_nxt = r_rshift;
      w_caps_nxt   = caps;
      if (w_event && w_plain) begin
         if (ps2_data == SC_LSHIFT) w_lshift_nxt = w_is_make;
         if (ps2_data == SC_RSHIFT) w_rshift_nxt = w_is_make;
         if ((ps2_data == SC_CAPS) && w_is_make && !w_repeat) w_caps_nxt = !caps;
      end

      // Modifier state before this event selects the glyph.
      w_ascii = (r_ext_pend || r_brk_pend) ? '0 : w_rom_ascii;
   end

   ps2_ascii_rom u_ascii_rom (
      .i_code    (ps2_data),
      .i_shift   (shift),
      .i_upper   (shift ^ caps),
      .o_ascii_c (w_rom_ascii)
   );

   // Datapath: pop strobe, prefix/skip tracking, event outputs, held key, counter.
   always_ff @(posedge clk) begin
      if (clrn) begin
         nextdata_n  <= 1'b1;
         key_valid   <= 1'b0;
         key_code    <= '0;
         key_ext     <= 1'b0;
         key_break   <= 1'b0;
         key_repeat  <= 1'b0;
         key_ascii   <= '0;
         shift       <= 1'b0;
         caps        <= 1'b0;
         press_count <= '0;
         r_skip_cnt  <= '0;
         r_ext_pend  <= 1'b0;
         r_brk_pend  <= 1'b0;
         r_held      <= '0;
         r_lshift    <= 1'b0;
         r_rshift    <= 1'b0;
      end else begin
         nextdata_n <= !w_capture;
         key_valid  <= w_event;
         r_lshift   <= w_lshift_nxt;
         r_rshift   <= w_rshift_nxt;
         shift      <= w_lshift_nxt | w_rshift_nxt;
         caps       <= w_caps_nxt;

         if (w_capture) begin
            if (w_in_skip) begin
               r_skip_cnt <= r_skip_cnt - SKIP_W'(1);
            end else if (ps2_data == SC_E1) begin
               // Pause sequence: swallow the fixed-length tail.
               r_skip_cnt <= SKIP_W'(E1_SKIP);
               r_ext_pend <= 1'b0;
               r_brk_pend <= 1'b0;
            end else if (ps2_data == SC_E0) begin
               r_ext_pend <= 1'b1;
            end else if (ps2_data == SC_F0) begin
               r_brk_pend <= 1'b1;
            end else if (is_status_byte(ps2_data)) begin
               r_ext_pend <= 1'b0;
               r_brk_pend <= 1'b0;
            end else begin
               key_code   <= ps2_data;
               key_ext    <= r_ext_pend;
               key_break  <= r_brk_pend;
               key_repeat <= w_repeat;
               key_ascii  <= w_ascii;
               r_ext_pend <= 1'b0;
               r_brk_pend <= 1'b0;
               if (w_is_make) begin
                  if (!w_held_match) begin
                     r_held      <= '{valid: 1'b1, ext: r_ext_pend, code: ps2_data};
                     press_count <= press_count + CNT_W'(1);
                  end
               end else if (w_held_match) begin
                  r_held.valid <= 1'b0;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
module tb_ps2_scancode_decoder;

   logic       clk = 1'b0;
   logic       clrn;
   logic [7:0] ps2_data;
   logic       ps2_ready;
   logic       nextdata_n;
   logic       key_valid;
   logic [7:0] key_code;
   logic       key_ext;
   logic       key_break;
   logic       key_repeat;
   logic [7:0] key_ascii;
   logic       shift;
   logic       caps;
   logic [7:0] press_count;

   always #5 clk = ~clk;

   ps2_scancode_decoder #(.CNT_W(8), .E1_SKIP(7)) dut (
      .clk         (clk),
      .clrn        (clrn),
      .ps2_data    (ps2_data),
      .ps2_ready   (ps2_ready),
      .nextdata_n  (nextdata_n),
      .key_valid   (key_valid),
      .key_code    (key_code),
      .key_ext     (key_ext),
      .key_break   (key_break),
      .key_repeat  (key_repeat),
      .key_ascii   (key_ascii),
      .shift       (shift),
      .caps        (caps),
      .press_count (press_count)
   );

   typedef struct {
      logic [7:0] code;
      logic       ext;
      logic       brk;
      logic       rep;
      logic [7:0] ascii;
      logic       shift;
      logic       caps;
      logic [7:0] cnt;
   } exp_t;

   exp_t       exp_q[$];
   logic [7:0] fifo[$];
   int         vectors = 0;
   int         errors  = 0;

   // Reference model state
   int         m_skip;
   bit         m_ext, m_brk, m_hv, m_hext, m_ls, m_rs, m_caps;
   logic [7:0] m_hcode;
   logic [7:0] m_cnt;

   function automatic logic [7:0] exp_ascii(input logic [7:0] c, input bit sh, input bit up);
      case (c)
         8'h1C:   return up ? 8'h41 : 8'h61;
         8'h32:   return up ? 8'h42 : 8'h62;
         8'h21:   return up ? 8'h43 : 8'h63;
         8'h16:   return sh ? 8'h21 : 8'h31;
         8'h1E:   return sh ? 8'h40 : 8'h32;
         8'h29:   return 8'h20;
         8'h5A:   return 8'h0D;
         8'h66:   return 8'h08;
         default: return 8'h00;
      endcase
   endfunction

   task automatic model_reset();
      m_skip = 0; m_ext = 0; m_brk = 0; m_hv = 0; m_hext = 0; m_hcode = 8'h00;
      m_ls = 0; m_rs = 0; m_caps = 0; m_cnt = 8'h00;
      exp_q.delete();
   endtask

   // Queue a byte into the FIFO and push any expected event to the scoreboard.
   task automatic send(input logic [7:0] b);
      exp_t e;
      bit   match, sh;
      fifo.push_back(b);
      if (m_skip > 0) m_skip--;
      else if (b == 8'hE1) begin m_skip = 7; m_ext = 0; m_brk = 0; end
      else if (b == 8'hE0) m_ext = 1;
      else if (b == 8'hF0) m_brk = 1;
      else if (b == 8'hAA || b == 8'hFA || b == 8'hFE || b == 8'hEE ||
               b == 8'h00 || b == 8'hFF) begin m_ext = 0; m_brk = 0; end
      else begin
         match   = m_hv && (m_hext == m_ext) && (m_hcode == b);
         sh      = m_ls | m_rs;
         e.code  = b;
         e.ext   = m_ext;
         e.brk   = m_brk;
         e.rep   = !m_brk && match;
         e.ascii = (m_ext || m_brk) ? 8'h00 : exp_ascii(b, sh, sh ^ m_caps);
         if (!m_brk) begin
            if (!match) begin m_hv = 1; m_hext = m_ext; m_hcode = b; m_cnt = m_cnt + 8'd1; end
            if (!m_ext) begin
               if (b == 8'h12) m_ls = 1;
               if (b == 8'h59) m_rs = 1;
               if (b == 8'h58 && !e.rep) m_caps = !m_caps;
            end
         end else begin
            if (match) m_hv = 0;
            if (!m_ext) begin
               if (b == 8'h12) m_ls = 0;
               if (b == 8'h59) m_rs = 0;
            end
         end
         e.shift = m_ls | m_rs;
         e.caps  = m_caps;
         e.cnt   = m_cnt;
         m_ext = 0; m_brk = 0;
         exp_q.push_back(e);
      end
   endtask

   // Serve the FIFO to the DUT and check every event against the scoreboard.
   task automatic drain(input int budget, output int pops, output int events);
      int   n = 0, idle = 0, last_pop = -1;
      bit   prev_low = 0, prev_kv = 0, more = 0;
      exp_t e;
      pops = 0; events = 0;
      ps2_ready = (fifo.size() != 0);
      ps2_data  = (fifo.size() != 0) ? fifo[0] : 8'h00;
      while (idle < 3 && n < budget) begin
         @(negedge clk);
         n++;
         if (key_valid) begin
            events++;
            vectors++;
            if (prev_kv) begin
               errors++;
               $display("FAIL key_valid_width: high two cycles in a row, want one-cycle pulse");
            end
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_event: got code=%h brk=%b, want no event", key_code, key_break);
            end else begin
               e = exp_q.pop_front();
               if ({key_code, key_ext, key_break, key_repeat, key_ascii, shift, caps, press_count} !==
                   {e.code, e.ext, e.brk, e.rep, e.ascii, e.shift, e.caps, e.cnt}) begin
                  errors++;
                  $display("FAIL event: got code=%h ext=%b brk=%b rep=%b ascii=%h shift=%b caps=%b cnt=%0d, want code=%h ext=%b brk=%b rep=%b ascii=%h shift=%b caps=%b cnt=%0d",
                           key_code, key_ext, key_break, key_repeat, key_ascii, shift, caps, press_count,
                           e.code, e.ext, e.brk, e.rep, e.ascii, e.shift, e.caps, e.cnt);
               end
            end
         end
         if (!nextdata_n) begin
            pops++;
            vectors++;
            if (!ps2_ready || prev_low) begin
               errors++;
               $display("FAIL pop_protocol: ready=%b prev_low=%b, want ready=1 prev_low=0", ps2_ready, prev_low);
            end
            if (last_pop >= 0 && more) begin
               vectors++;
               if (n - last_pop != 2) begin
                  errors++;
                  $display("FAIL pop_gap: got %0d cycles, want 2", n - last_pop);
               end
            end
            last_pop = n;
            if (fifo.size() != 0) void'(fifo.pop_front());
            more = (fifo.size() != 0);
         end
         prev_low  = !nextdata_n;
         prev_kv   = key_valid;
         ps2_ready = (fifo.size() != 0);
         ps2_data  = (fifo.size() != 0) ? fifo[0] : 8'h00;
         if (fifo.size() == 0 && nextdata_n && !key_valid) idle++;
         else idle = 0;
      end
      vectors++;
      if (idle < 3) begin
         errors++;
         $display("FAIL drain_timeout: %0d bytes left after %0d cycles, want 0", fifo.size(), n);
      end
      vectors++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL missing_events: got %0d outstanding, want 0", exp_q.size());
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      clrn = 1'b1;
      fifo.delete();
      ps2_ready = 1'b0;
      ps2_data  = 8'h00;
      repeat (2) @(negedge clk);
      clrn = 1'b0;
      model_reset();
   endtask

   task automatic test_reset();
      clrn = 1'b1;
      ps2_ready = 1'b1;     // reset must win over an available byte
      ps2_data  = 8'h1C;
      repeat (3) @(negedge clk);
      vectors++;
      if ({nextdata_n, key_valid, key_code, key_ext, key_break, key_repeat, key_ascii, shift, caps, press_count} !==
          {1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00}) begin
         errors++;
         $display("FAIL reset_state: got nextdata_n=%b kv=%b code=%h ascii=%h shift=%b caps=%b cnt=%0d, want 1 0 00 00 0 0 0",
                  nextdata_n, key_valid, key_code, key_ascii, shift, caps, press_count);
      end
      ps2_ready = 1'b0;
      clrn = 1'b0;
      model_reset();
   endtask

   task automatic test_basic();
      int p, ev;
      do_reset();
      send(8'h1C); send(8'hF0); send(8'h1C);
      drain(40, p, ev);
      vectors++;
      if (ev != 2 || press_count !== 8'd1) begin
         errors++;
         $display("FAIL basic: got events=%0d count=%0d, want 2 1", ev, press_count);
      end
   endtask

   task automatic test_shift();
      int p, ev;
      do_reset();
      send(8'h12); send(8'h1C); send(8'hF0); send(8'h1C); send(8'hF0); send(8'h12);
      drain(60, p, ev);
      vectors++;
      if (shift !== 1'b0 || press_count !== 8'd2) begin
         errors++;
         $display("FAIL shift_end: got shift=%b count=%0d, want 0 2", shift, press_count);
      end
      // Right shift, digits and fixed glyphs
      send(8'h59); send(8'h32); send(8'h16); send(8'hF0); send(8'h59);
      send(8'h16); send(8'h1E); send(8'h66); send(8'h29); send(8'h5A);
      drain(100, p, ev);
   endtask

   task automatic test_caps();
      int p, ev;
      do_reset();
      send(8'h58); send(8'hF0); send(8'h58); send(8'h1C);
      drain(50, p, ev);
      vectors++;
      if (caps !== 1'b1) begin
         errors++;
         $display("FAIL caps_on: got %b, want 1", caps);
      end
      send(8'h12); send(8'h21); send(8'hF0); send(8'h12);  // shift with caps gives lower case
      send(8'h58); send(8'h58);                           // second make is typematic, no toggle
      drain(80, p, ev);
      vectors++;
      if (caps !== 1'b0) begin
         errors++;
         $display("FAIL caps_off: got %b, want 0", caps);
      end
   endtask

   task automatic test_ext();
      int p, ev;
      do_reset();
      send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
      send(8'hE0); send(8'hAA); send(8'h76);               // status byte clears the prefix
      drain(60, p, ev);
      vectors++;
      if (ev != 3) begin
         errors++;
         $display("FAIL ext_events: got %0d, want 3", ev);
      end
   endtask

   task automatic test_repeat();
      int p, ev;
      do_reset();
      send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C);
      send(8'h1C);                                        // held cleared: counts again
      drain(60, p, ev);
      vectors++;
      if (press_count !== 8'd2) begin
         errors++;
         $display("FAIL repeat_count: got %0d, want 2", press_count);
      end
   endtask

   task automatic test_e1_skip();
      int p, ev;
      do_reset();
      send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
      send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
      send(8'h1C);
      drain(80, p, ev);
      vectors++;
      if (ev != 1 || key_code !== 8'h1C || key_break !== 1'b0) begin
         errors++;
         $display("FAIL e1_skip: got events=%0d code=%h brk=%b, want 1 1c 0", ev, key_code, key_break);
      end
   endtask

   task automatic test_back_to_back();
      int p, ev;
      do_reset();
      send(8'h1C); send(8'h32); send(8'h21); send(8'h29); send(8'h5A);
      drain(60, p, ev);
      vectors++;
      if (p != 5 || ev != 5) begin
         errors++;
         $display("FAIL back_to_back: got pops=%0d events=%0d, want 5 5", p, ev);
      end
   endtask

   task automatic test_wrap();
      int p, ev;
      do_reset();
      for (int i = 0; i < 258; i++) send((i % 2 == 0) ? 8'h1C : 8'h32);
      drain(1200, p, ev);
      vectors++;
      if (press_count !== 8'd2) begin
         errors++;
         $display("FAIL count_wrap: got %0d, want 2", press_count);
      end
   endtask

   task automatic test_reset_in_pop();
      int n = 0;
      do_reset();
      fifo.push_back(8'h1C);
      ps2_ready = 1'b1;
      ps2_data  = 8'h1C;
      while (nextdata_n && n < 10) begin
         @(negedge clk);
         n++;
      end
      vectors++;
      if (nextdata_n !== 1'b0 || key_valid !== 1'b1 || key_code !== 8'h1C || press_count !== 8'd1) begin
         errors++;
         $display("FAIL pop_before_reset: got nextdata_n=%b kv=%b code=%h cnt=%0d, want 0 1 1c 1",
                  nextdata_n, key_valid, key_code, press_count);
      end
      clrn = 1'b1;
      @(negedge clk);
      vectors++;
      if (nextdata_n !== 1'b1 || key_valid !== 1'b0 || key_code !== 8'h00 || press_count !== 8'd0) begin
         errors++;
         $display("FAIL reset_in_pop: got nextdata_n=%b kv=%b code=%h cnt=%0d, want 1 0 00 0",
                  nextdata_n, key_valid, key_code, press_count);
      end
      fifo.delete();
      ps2_ready = 1'b0;
      clrn = 1'b0;
      model_reset();
   endtask

   initial begin
      clrn      = 1'b1;
      ps2_ready = 1'b0;
      ps2_data  = 8'h00;
      model_reset();
      test_reset();
      test_basic();
      test_shift();
      test_caps();
      test_ext();
      test_repeat();
      test_e1_skip();
      test_back_to_back();
      test_wrap();
      test_reset_in_pop();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
